// File: rtl/sram_wr_arbiter_if.sv
// sram_wr_arbiter_if: bundle of the ingress-port handshake, the SRAM write
// port and the completed-packet report of the packet SRAM write arbiter.
//
//   wr_req/wr_valid/wr_last  16-bit per-port request, word valid, last flag
//   wr_data                  16 ports x DATA_WIDTH, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   wr_grant                 one-hot registered grant back to the ports
//   sram_wr_en/addr/data     registered SRAM write port
//   pkt_done/port/base/len/err  per-packet completion report
//
// Modports: master = ingress ports + downstream consumers, slave = arbiter.
interface sram_wr_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
);
  logic [15:0]              wr_req;
  logic [15:0]              wr_valid;
  logic [15:0]              wr_last;
  logic [16*DATA_WIDTH-1:0] wr_data;
  logic [15:0]              wr_grant;
  logic                     sram_wr_en;
  logic [ADDR_WIDTH-1:0]    sram_wr_addr;
  logic [DATA_WIDTH-1:0]    sram_wr_data;
  logic                     pkt_done;
  logic [3:0]               pkt_port;
  logic [ADDR_WIDTH-1:0]    pkt_base;
  logic [6:0]               pkt_len;
  logic                     pkt_err;

  modport master (
    output wr_req, wr_valid, wr_last, wr_data,
    input  wr_grant, sram_wr_en, sram_wr_addr, sram_wr_data,
    input  pkt_done, pkt_port, pkt_base, pkt_len, pkt_err
  );

  modport slave (
    input  wr_req, wr_valid, wr_last, wr_data,
    output wr_grant, sram_wr_en, sram_wr_addr, sram_wr_data,
    output pkt_done, pkt_port, pkt_base, pkt_len, pkt_err
  );
endinterface

// File: rtl/sram_wr_arbiter.sv
// sram_wr_arbiter: write-side arbiter of the shared packet SRAM. Grants one
// of 16 ingress ports at a time for a whole packet (round-robin), forwards
// its words to a registered SRAM write port at consecutive addresses and
// reports every finished packet (port, base address, length, error).
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    sram_wr_arbiter_if.slave (ingress handshake, SRAM write port,
//          packet report)
//
// Optional feature: define WR_TIMEOUT_EN to abort a packet whose granted
// port keeps wr_valid low for TIMEOUT consecutive cycles. Without it a
// granted port may stall forever and TIMEOUT is only range-checked.
module sram_wr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_BURST  = 64,
  parameter int TIMEOUT    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_wr_arbiter_if.slave bus
);
  localparam int LEN_W = 7;

  // pkt_len is 7 bits wide, so a burst can never exceed 127 words.
  if (MAX_BURST < 2 || MAX_BURST > 127 || TIMEOUT < 1) begin : g_param_check
    $error("sram_wr_arbiter: MAX_BURST must be 2..127 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_t                 state_q, state_d;
  logic [15:0]            mask_q, mask_d;
  logic [15:0]            grant_q, grant_d;
  logic [3:0]             port_q, port_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [LEN_W-1:0]       count_q, count_d;
  logic                   sram_en_q, sram_en_d;
  logic [ADDR_WIDTH-1:0]  sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]  sram_data_q, sram_data_d;
  logic                   done_q, done_d;
  logic [3:0]             pkt_port_q, pkt_port_d;
  logic [ADDR_WIDTH-1:0]  pkt_base_q, pkt_base_d;
  logic [LEN_W-1:0]       pkt_len_q, pkt_len_d;
  logic                   pkt_err_q, pkt_err_d;
`ifdef WR_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  logic [ST_W-1:0]        stall_q, stall_d;
`endif

  logic [15:0]            masked_req, eligible;
  logic [3:0]             pick;
  logic                   accept, last_word, burst_full, end_pkt, timeout_hit;
  logic [LEN_W-1:0]       cnt_inc;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Arbitration and granted-port decode
  always_comb begin
    masked_req = mask_q & bus.wr_req;
    // Once every pending requester has had its turn, start a new round.
    eligible   = (|masked_req) ? masked_req : bus.wr_req;
    pick       = lowest_idx(eligible);
    accept     = (state_q == XFER) && bus.wr_valid[port_q];
    last_word  = bus.wr_last[port_q];
    sel_data   = bus.wr_data[port_q*DATA_WIDTH +: DATA_WIDTH];
    cnt_inc    = count_q + LEN_W'(1);
    burst_full = (cnt_inc == LEN_W'(MAX_BURST));
    end_pkt    = accept && (last_word || burst_full);
`ifdef WR_TIMEOUT_EN
    timeout_hit = (state_q == XFER) && !bus.wr_valid[port_q] &&
                  ((stall_q + ST_W'(1)) == ST_W'(TIMEOUT));
`else
    timeout_hit = 1'b0;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.wr_req) state_d = XFER;
      XFER:    if (end_pkt || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    mask_d      = mask_q;
    grant_d     = grant_q;
    port_d      = port_q;
    wr_ptr_d    = wr_ptr_q;
    base_d      = base_q;
    count_d     = count_q;
    sram_en_d   = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_data_d = sram_data_q;
    done_d      = 1'b0;
    pkt_port_d  = pkt_port_q;
    pkt_base_d  = pkt_base_q;
    pkt_len_d   = pkt_len_q;
    pkt_err_d   = pkt_err_q;
`ifdef WR_TIMEOUT_EN
    stall_d     = stall_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.wr_req) begin
          grant_d = 16'b1 << pick;
          port_d  = pick;
          base_d  = wr_ptr_q;
          count_d = '0;
          mask_d  = (|masked_req) ? (mask_q & ~(16'b1 << pick)) : ~(16'b1 << pick);
`ifdef WR_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      XFER: begin
        if (accept) begin
          sram_en_d   = 1'b1;
          sram_addr_d = wr_ptr_q;
          sram_data_d = sel_data;
          wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(1);
          count_d     = cnt_inc;
`ifdef WR_TIMEOUT_EN
          stall_d     = '0;
`endif
          if (end_pkt) begin
            // Report lands in the same cycle as the final SRAM write.
            grant_d    = '0;
            done_d     = 1'b1;
            pkt_port_d = port_q;
            pkt_base_d = base_q;
            pkt_len_d  = cnt_inc;
            pkt_err_d  = !last_word;
          end
        end else if (timeout_hit) begin
          // Abort: words already written stay in the SRAM.
          grant_d    = '0;
          done_d     = 1'b1;
          pkt_port_d = port_q;
          pkt_base_d = base_q;
          pkt_len_d  = count_q;
          pkt_err_d  = 1'b1;
        end else begin
`ifdef WR_TIMEOUT_EN
          stall_d = stall_q + ST_W'(1);
`endif
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and report registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q      <= 16'hFFFF;
      grant_q     <= '0;
      port_q      <= '0;
      wr_ptr_q    <= '0;
      base_q      <= '0;
      count_q     <= '0;
      sram_en_q   <= 1'b0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      done_q      <= 1'b0;
      pkt_port_q  <= '0;
      pkt_base_q  <= '0;
      pkt_len_q   <= '0;
      pkt_err_q   <= 1'b0;
`ifdef WR_TIMEOUT_EN
      stall_q     <= '0;
`endif
    end else begin
      mask_q      <= mask_d;
      grant_q     <= grant_d;
      port_q      <= port_d;
      wr_ptr_q    <= wr_ptr_d;
      base_q      <= base_d;
      count_q     <= count_d;
      sram_en_q   <= sram_en_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      done_q      <= done_d;
      pkt_port_q  <= pkt_port_d;
      pkt_base_q  <= pkt_base_d;
      pkt_len_q   <= pkt_len_d;
      pkt_err_q   <= pkt_err_d;
`ifdef WR_TIMEOUT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign bus.wr_grant     = grant_q;
  assign bus.sram_wr_en   = sram_en_q;
  assign bus.sram_wr_addr = sram_addr_q;
  assign bus.sram_wr_data = sram_data_q;
  assign bus.pkt_done     = done_q;
  assign bus.pkt_port     = pkt_port_q;
  assign bus.pkt_base     = pkt_base_q;
  assign bus.pkt_len      = pkt_len_q;
  assign bus.pkt_err      = pkt_err_q;
endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Testbench for sram_wr_arbiter: per-port packet drivers respond to the
// grant, a model of the write pointer predicts SRAM writes and packet
// reports into queues, and the monitor pops and compares them.
module tb_sram_wr_arbiter;
  localparam int DW   = 16;
  localparam int AW   = 14;
  localparam int MAXB = 64;
  localparam int TMO  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [3:0] port; logic [AW-1:0] base; logic [6:0] len; logic err; logic wr; } pk_t;

  wr_t exp_w[$];
  pk_t exp_p[$];
  int  exp_g[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int pkts_left[16], plen[16], word_i[16], stall_at[16], stall_len[16], stall_cnt[16], last_word_cyc[16];
  logic plast[16];
  logic [AW-1:0] pbase[16];
  logic [AW-1:0] mptr = '0;
  logic [11:0] seq = '0;

  logic [15:0] prev_grant = '0;
  int drop_cyc = 0;
  int bub_from = 0;
  logic chk_bubble = 1'b0;
  logic rst_pending = 1'b0;
  logic [AW-1:0] last_pkt_base = '0;
  logic [6:0] last_pkt_len = '0;
  logic last_pkt_err = 1'b0;
  int last_done_cyc = 0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_model();
    for (int p = 0; p < 16; p++) begin
      pkts_left[p] = 0; plen[p] = 0; word_i[p] = 0; stall_at[p] = -1;
      stall_len[p] = 0; stall_cnt[p] = 0; plast[p] = 1'b0; pbase[p] = '0;
      last_word_cyc[p] = 0;
    end
    exp_w.delete(); exp_p.delete(); exp_g.delete();
    mptr = '0;
  endtask

  task automatic program_port(input int p, input int n, input int len, input logic lst,
                              input int st_at, input int st_len);
    pkts_left[p] = n; plen[p] = len; plast[p] = lst; word_i[p] = 0;
    stall_at[p] = st_at; stall_len[p] = st_len; stall_cnt[p] = 0;
  endtask

  // One cycle: observe outputs at the falling edge, then drive the inputs
  // for the next rising edge.
  task automatic step();
    wr_t e;
    pk_t k;
    logic [DW-1:0] d;
    logic is_last;
    int g;
    @(negedge clk);
    cyc++;

    n_checks++;
    if (!$onehot0(bus.wr_grant)) begin
      n_fail++;
      $display("FAIL grant_onehot: got %h, required at most one bit set", bus.wr_grant);
    end
    if (bus.wr_grant != 16'h0 && prev_grant == 16'h0) begin
      if (exp_g.size() > 0) begin
        g = exp_g.pop_front();
        n_checks++;
        if (bus.wr_grant !== (16'h1 << g)) begin
          n_fail++;
          $display("FAIL grant_order: got %h, required %h", bus.wr_grant, 16'h1 << g);
        end
      end
      if (chk_bubble && drop_cyc > bub_from) begin
        n_checks++;
        if (cyc - drop_cyc != 1) begin
          n_fail++;
          $display("FAIL idle_bubble: got %0d idle cycles, required 1", cyc - drop_cyc);
        end
      end
    end
    if (bus.wr_grant == 16'h0 && prev_grant != 16'h0) drop_cyc = cyc;

    if (bus.sram_wr_en === 1'b1) begin
      n_checks++;
      if (exp_w.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", bus.sram_wr_addr, bus.sram_wr_data);
      end else begin
        e = exp_w.pop_front();
        if (bus.sram_wr_addr !== e.addr || bus.sram_wr_data !== e.data) begin
          n_fail++;
          $display("FAIL sram_write: got addr %0d data %h, required addr %0d data %h",
                   bus.sram_wr_addr, bus.sram_wr_data, e.addr, e.data);
        end
      end
    end

    if (bus.pkt_done === 1'b1) begin
      last_pkt_base = bus.pkt_base; last_pkt_len = bus.pkt_len;
      last_pkt_err = bus.pkt_err; last_done_cyc = cyc;
      n_checks++;
      if (exp_p.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pkt_done: got port %0d base %0d len %0d err %0d, required none",
                 bus.pkt_port, bus.pkt_base, bus.pkt_len, bus.pkt_err);
      end else begin
        k = exp_p.pop_front();
        if (bus.pkt_port !== k.port || bus.pkt_base !== k.base || bus.pkt_len !== k.len ||
            bus.pkt_err !== k.err || bus.sram_wr_en !== k.wr) begin
          n_fail++;
          $display("FAIL pkt_report: got port %0d base %0d len %0d err %0d wr_en %0d, required port %0d base %0d len %0d err %0d wr_en %0d",
                   bus.pkt_port, bus.pkt_base, bus.pkt_len, bus.pkt_err, bus.sram_wr_en,
                   k.port, k.base, k.len, k.err, k.wr);
        end
      end
    end
    prev_grant = bus.wr_grant;

    if (rst_pending) begin
      rst_pending = 1'b0;
      rst_n = 1'b0;
      clear_model();
      bus.wr_req = '0; bus.wr_valid = '0; bus.wr_last = '0; bus.wr_data = '0;
    end else begin
      rst_n = 1'b1;
      for (int p = 0; p < 16; p++) begin
        bus.wr_valid[p] = 1'b0;
        bus.wr_last[p]  = 1'b0;
        bus.wr_data[p*DW +: DW] = DW'($urandom);
        // A packet the DUT aborted while this port stalled is abandoned.
        if (bus.wr_grant[p] !== 1'b1 && word_i[p] > 0) begin
          pkts_left[p]--; word_i[p] = 0; stall_cnt[p] = 0;
        end
        if (bus.wr_grant[p] === 1'b1 && pkts_left[p] > 0) begin
          if (word_i[p] == stall_at[p] && stall_cnt[p] < stall_len[p]) begin
            stall_cnt[p]++;
          end else begin
            if (word_i[p] == 0) pbase[p] = mptr;
            seq++;
            d = DW'({p[3:0], seq});
            is_last = plast[p] && (word_i[p] == plen[p] - 1);
            bus.wr_valid[p] = 1'b1;
            bus.wr_last[p]  = is_last;
            bus.wr_data[p*DW +: DW] = d;
            exp_w.push_back('{addr: mptr, data: d});
            mptr++;
            word_i[p]++;
            last_word_cyc[p] = cyc;
            if (is_last || word_i[p] == MAXB) begin
              exp_p.push_back('{port: 4'(p), base: pbase[p], len: 7'(word_i[p]), err: !is_last, wr: 1'b1});
              word_i[p] = 0; stall_cnt[p] = 0; pkts_left[p]--;
            end
          end
        end else if (pkts_left[p] > 0) begin
          // Noise on a waiting port: must be ignored by the arbiter.
          bus.wr_valid[p] = 1'b1;
          bus.wr_last[p]  = 1'b1;
        end
        bus.wr_req[p] = (pkts_left[p] > 0);
      end
    end
  endtask

  task automatic run_idle(input int bound);
    logic done;
    int busy;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      busy = 0;
      for (int p = 0; p < 16; p++) busy += pkts_left[p];
      done = (busy == 0) && (exp_w.size() == 0) && (exp_p.size() == 0) && (bus.wr_grant == 16'h0);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: got traffic pending after %0d cycles, required idle", bound);
    end
    step(); step();
    n_checks++;
    if (exp_w.size() != 0 || exp_p.size() != 0 || exp_g.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expectations: got writes %0d pkts %0d grants %0d outstanding, required 0",
               exp_w.size(), exp_p.size(), exp_g.size());
    end
  endtask

  task automatic test_reset();
    bus.wr_req = '0; bus.wr_valid = '0; bus.wr_last = '0; bus.wr_data = '0;
    rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.wr_grant !== 16'h0 || bus.sram_wr_en !== 1'b0 || bus.sram_wr_addr !== '0 ||
        bus.sram_wr_data !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got grant %h en %b addr %0d data %h, required all 0",
               bus.wr_grant, bus.sram_wr_en, bus.sram_wr_addr, bus.sram_wr_data);
    end
    n_checks++;
    if (bus.pkt_done !== 1'b0 || bus.pkt_port !== 4'h0 || bus.pkt_base !== '0 ||
        bus.pkt_len !== 7'h0 || bus.pkt_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pkt: got done %b port %0d base %0d len %0d err %b, required all 0",
               bus.pkt_done, bus.pkt_port, bus.pkt_base, bus.pkt_len, bus.pkt_err);
    end
    step();
  endtask

  task automatic test_single();
    program_port(3, 1, 4, 1'b1, -1, 0);
    exp_g.push_back(3);
    step();
    step();
    n_checks++;
    if (bus.wr_grant !== 16'h0008) begin
      n_fail++;
      $display("FAIL single_grant_latency: got %h, required 0008", bus.wr_grant);
    end
    run_idle(50);
    n_checks++;
    if (last_pkt_base !== 14'd0 || last_pkt_len !== 7'd4 || last_pkt_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_report: got base %0d len %0d err %b, required base 0 len 4 err 0",
               last_pkt_base, last_pkt_len, last_pkt_err);
    end
  endtask

  task automatic test_round_robin();
    chk_bubble = 1'b1;
    bub_from = cyc;
    program_port(1, 2, 2, 1'b1, -1, 0);
    program_port(5, 2, 2, 1'b1, -1, 0);
    program_port(9, 2, 2, 1'b1, -1, 0);
    exp_g.push_back(1); exp_g.push_back(5); exp_g.push_back(9);
    exp_g.push_back(1); exp_g.push_back(5); exp_g.push_back(9);
    run_idle(100);
    chk_bubble = 1'b0;
  endtask

  task automatic test_truncation();
    program_port(0, 1, 70, 1'b0, -1, 0);
    program_port(8, 1, 3, 1'b1, -1, 0);
    exp_g.push_back(0); exp_g.push_back(8);
    run_idle(200);
  endtask

  task automatic test_stall();
    program_port(7, 1, 3, 1'b1, 1, 40);
`ifdef WR_TIMEOUT_EN
    exp_p.push_back('{port: 4'd7, base: mptr, len: 7'd1, err: 1'b1, wr: 1'b0});
`endif
    run_idle(200);
`ifdef WR_TIMEOUT_EN
    n_checks++;
    if (last_done_cyc - last_word_cyc[7] != TMO + 1 || last_pkt_len !== 7'd1 || last_pkt_err !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_timeout: got done %0d cycles after word, len %0d err %b, required %0d cycles len 1 err 1",
               last_done_cyc - last_word_cyc[7], last_pkt_len, last_pkt_err, TMO + 1);
    end
`else
    n_checks++;
    if (last_pkt_len !== 7'd3 || last_pkt_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_no_abort: got len %0d err %b, required len 3 err 0", last_pkt_len, last_pkt_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    program_port(0, 1, 5, 1'b1, -1, 0);
    exp_g.push_back(0);
    for (int i = 0; i < 20 && word_i[0] != 2; i++) step();
    n_checks++;
    if (word_i[0] != 2) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got %0d words sent, required 2", word_i[0]);
    end
    rst_pending = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.wr_grant !== 16'h0 || bus.sram_wr_en !== 1'b0 || bus.sram_wr_addr !== '0 ||
        bus.sram_wr_data !== '0 || bus.pkt_done !== 1'b0 || bus.pkt_port !== 4'h0 ||
        bus.pkt_base !== '0 || bus.pkt_len !== 7'h0 || bus.pkt_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got grant %h en %b addr %0d data %h done %b port %0d base %0d len %0d err %b, required all 0",
               bus.wr_grant, bus.sram_wr_en, bus.sram_wr_addr, bus.sram_wr_data, bus.pkt_done,
               bus.pkt_port, bus.pkt_base, bus.pkt_len, bus.pkt_err);
    end
    program_port(0, 1, 2, 1'b1, -1, 0);
    program_port(3, 1, 2, 1'b1, -1, 0);
    exp_g.push_back(0); exp_g.push_back(3);
    run_idle(50);
  endtask

  task automatic test_wrap();
    int rem;
    rem = 16382 - int'(mptr);
    if (rem / 64 > 0) begin
      program_port(2, rem / 64, 64, 1'b1, -1, 0);
      run_idle(20000);
    end
    if (rem % 64 > 0) begin
      program_port(2, 1, rem % 64, 1'b1, -1, 0);
      run_idle(200);
    end
    program_port(4, 1, 4, 1'b1, -1, 0);
    exp_g.push_back(4);
    run_idle(50);
    n_checks++;
    if (last_pkt_base !== 14'd16382 || last_pkt_len !== 7'd4 || last_pkt_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_report: got base %0d len %0d err %b, required base 16382 len 4 err 0",
               last_pkt_base, last_pkt_len, last_pkt_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_truncation();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
